// File: rtl/reload_sched_pkg.sv
// rtl/reload_sched_pkg.sv - shared types and defaults for the reload scheduler
package reload_sched_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_DEPTH  = 4;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    LOAD,
    HOLD
  } sched_state_t;

endpackage

// File: rtl/reload_scheduler_if.sv
// rtl/reload_scheduler_if.sv - producer/counter-facing bundle of the reload scheduler
interface reload_scheduler_if #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic              wr_valid_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              wr_ready_o;
  logic [DATA_W-1:0] count_i;
  logic              load_o;
  logic [DATA_W-1:0] load_val_o;
  logic [LVL_W-1:0]  level_o;
  logic              underrun_o;

  modport master (
    output wr_valid_i, wr_data_i, count_i,
    input  wr_ready_o, load_o, load_val_o, level_o, underrun_o
  );

  modport slave (
    input  wr_valid_i, wr_data_i, count_i,
    output wr_ready_o, load_o, load_val_o, level_o, underrun_o
  );

endinterface

// File: rtl/reload_fifo.sv
// rtl/reload_fifo.sv - synchronous reload-value FIFO with occupancy-based full/empty
module reload_fifo
  import reload_sched_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == LVL_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reload_scheduler.sv
// rtl/reload_scheduler.sv - issues one counter reload per terminal count from a FIFO of values
module reload_scheduler
  import reload_sched_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter logic [DATA_W-1:0] TERM_VAL = {DATA_W{1'b1}},
  localparam int               LVL_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  reload_scheduler_if.slave bus
);

  sched_state_t      state;
  sched_state_t      state_nx;
  logic              term;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] head;
  logic [LVL_W-1:0]  level;
  logic              load_q;
  logic              load_nx;
  logic              underrun_q;
  logic              underrun_nx;
  logic [DATA_W-1:0] val_q;

  assign term = (bus.count_i == TERM_VAL);
  assign push = bus.wr_valid_i && !full;

  reload_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus.wr_data_i),
    .head  (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_nx    = state;
    load_nx     = 1'b0;
    underrun_nx = 1'b0;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (term) begin
          underrun_nx = 1'b1;
          state_nx    = HOLD;
        end else if (push) begin
          state_nx = ARMED;
        end
      end
      ARMED: begin
        if (term) begin
          pop      = 1'b1;
          load_nx  = 1'b1;
          state_nx = LOAD;
        end
      end
      LOAD: begin
        state_nx = HOLD;
      end
      HOLD: begin
        // A push landing on the exit edge must still arm, or its entry would sit unused in IDLE.
        if (!term) begin
          state_nx = (!empty || push) ? ARMED : IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      load_q     <= 1'b0;
      underrun_q <= 1'b0;
      val_q      <= '0;
    end else begin
      state      <= state_nx;
      load_q     <= load_nx;
      underrun_q <= underrun_nx;
      if (load_nx) begin
        val_q <= head;
      end
    end
  end

  assign bus.wr_ready_o = !full;
  assign bus.load_o     = load_q;
  assign bus.load_val_o = val_q;
  assign bus.level_o    = level;
  assign bus.underrun_o = underrun_q;

endmodule
